// File: rtl/store_pkg.sv
// Shared definitions for the store unit: store-type codes, FSM encoding and
// memory-latency limits.
package store_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 4;
    localparam int unsigned CNT_W       = 3;

    localparam logic [1:0] ST_SW  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SB  = 2'b10;
    localparam logic [1:0] ST_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Out-of-range latencies are pulled into the legal window so the counter never overflows.
    function automatic int unsigned clamp_lat(input int unsigned lat);
        if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
        if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
        return lat;
    endfunction

    function automatic logic store_err(input logic [1:0] st, input logic [1:0] off);
        return (st == ST_RSV) || ((st == ST_SH) && off[0]) || ((st == ST_SW) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lane_merge.sv
// Combinational little-endian lane merge: overlays the store operand onto the
// word read back from memory.
module lane_merge
    import store_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      type_i,
    input  logic [1:0]      off_i,
    output logic [XLEN-1:0] merged_o
);

    always_comb begin
        merged_o = rdata_i;
        case (type_i)
            ST_SW:   merged_o = data_i;
            ST_SH:   merged_o[{off_i[1], 4'b0000} +: 16] = data_i[15:0];
            ST_SB:   merged_o[{off_i, 3'b000} +: 8]      = data_i[7:0];
            default: merged_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: word stores write directly, sub-word stores read-modify-write the
// containing word. Start/done handshake with the control FSM.
module store_unit
    import store_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      store_type,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] data_in,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int unsigned LAT = clamp_lat(MEM_LAT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        type_q, type_d;
    logic [1:0]        off_q, off_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   merged;

    lane_merge u_merge (
        .rdata_i  (mem_rdata),
        .data_i   (data_q),
        .type_i   (type_q),
        .off_i    (off_q),
        .merged_o (merged)
    );

    // Next-state and next-output logic; outputs are decoded from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        type_d      = type_q;
        off_d       = off_q;
        data_d      = data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    type_d = store_type;
                    off_d  = addr[1:0];
                    data_d = data_in;
                    err_d  = 1'b0;
                    cnt_d  = '0;
                    if (store_err(store_type, addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        mem_addr_d = {addr[XLEN-1:2], 2'b00};
                        if (store_type == ST_SW) begin
                            mem_wdata_d = data_in;
                            state_d     = S_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                // Read data is taken on the edge that ends the LAT+1'th READ cycle.
                if (cnt_q == CNT_W'(LAT)) begin
                    mem_wdata_d = merged;
                    state_d     = S_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        mem_we_d = (state_d == S_WRITE);
        done_d   = (state_d == S_DONE);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            type_q      <= '0;
            off_q       <= '0;
            data_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            type_q      <= type_d;
            off_q       <= off_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Memory-side counterpart of the write-back path: moves register data into memory for sw, sh and sb.
- Word stores are written directly.
- Halfword and byte stores do a read-modify-write on the word-addressed memory, so the other byte lanes are preserved.
- Driven by the main control FSM with a start/done handshake; owns the memory address, write data and write-enable while busy.

Parameters:
- MEM_LAT, 1, memory read latency in cycles; legal values 1..4.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- store_type  in  2  00=sw, 01=sh, 10=sb, 11=reserved
- addr  in  32  byte address
- data_in  in  32  register operand (B register)
- mem_rdata  in  32  memory read data
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write enable
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  misaligned access or reserved type; held until the next accepted start

Behaviour:
- Reset (asynchronous, active-low):
  - state returns to IDLE immediately; a write in flight is aborted.
  - mem_we, done, err, busy = 0; mem_addr = 0; mem_wdata = 0.
  - Latched operands are cleared.
- States: IDLE, READ, WRITE, DONE. All outputs are registered; busy is decoded from state.
- IDLE:
  - start=1 latches addr, data_in and store_type, and clears err.
  - Error check: err is set and the next state is DONE, with no memory access, when any of these holds: store_type=11; sh with addr[0]=1; sw with addr[1:0]!=0.
  - Otherwise sw goes to WRITE; sh and sb go to READ.
- READ:
  - mem_addr = {addr[31:2],2'b00}, mem_we=0.
  - Held MEM_LAT+1 cycles, counted by an internal counter.
  - At the edge ending the last READ cycle, mem_rdata is captured and merged; next state is WRITE.
- Merge rules (little-endian lanes):
  - sb replaces byte lane addr[1:0] with data_in[7:0].
  - sh replaces halfword lane addr[1] with data_in[15:0].
  - All other lanes keep the captured read word.
  - sw uses data_in unmodified.
- WRITE:
  - Lasts exactly 1 cycle with mem_we=1, mem_addr word-aligned, mem_wdata = the merged or direct word.
  - Next state is DONE.
- DONE:
  - done=1 for exactly 1 cycle, mem_we=0; next state is IDLE.
  - err stays valid through DONE and afterwards.
- Latency from the start edge to the done-high cycle:
  - sw: 2 cycles.
  - sh/sb: MEM_LAT+3 cycles.
  - Error: 1 cycle.
- start asserted while busy is ignored (not queued).
- Inputs are captured at start, so changes to addr, data_in or store_type during busy have no effect.
- start high in the same cycle as done: not accepted (state is DONE); it is accepted on the following IDLE cycle if still high.
- mem_we is never high outside WRITE, including across reset assertion and deassertion.
- Address wrap: mem_addr is truncated to a word boundary only; there is no overflow handling.

Decomposition:
- Shared package store_pkg holds:
  - store-type constants ST_SW, ST_SH, ST_SB, ST_RSV.
  - FSM state encoding.
  - MEM_LAT range limits.
- One natural sub-module, lane_merge, is combinational: inputs are the read word, data_in, store_type and addr[1:0]; output is the merged word. It is reused by the bench as the reference model.

Test Plan:
- sw, addr=0x0000_0010, data_in=0xDEADBEEF:
  - WRITE occurs 1 cycle after start with mem_addr=0x10, mem_wdata=0xDEADBEEF, mem_we high for 1 cycle.
  - done 2 cycles after start; err=0.
- sb, addr=0x0000_0013, data_in=0x000000AB, mem_rdata=0x11223344, MEM_LAT=1:
  - READ lasts 2 cycles.
  - WRITE mem_wdata=0xAB223344 at mem_addr=0x10.
  - done 4 cycles after start.
- sh, addr=0x0000_0022, data_in=0x0000CAFE, mem_rdata=0x11223344:
  - mem_wdata=0xCAFE3344.
  - Repeat with MEM_LAT=3: READ lasts 4 cycles, done 6 cycles after start.
- Errors:
  - sh at addr=0x0000_0021 and sw at addr=0x0000_0002: no mem_we, done 1 cycle after start, err=1 held until the next start.
  - store_type=11: same response.
- Reset and handshake:
  - reset_n pulsed low during WRITE: mem_we drops asynchronously, all outputs reset, FSM is in IDLE.
  - start held high during busy and through done: exactly one extra transaction begins, in the cycle after DONE.
